// File: rtl/array_extreme_finder.sv
// array_extreme_finder
//   Walks a DEPTH-entry synchronous-read memory once per request and reports
//   the maximum (mode=0) or minimum (mode=1) element and the lowest index
//   holding it. Each element takes four cycles: READ, CAPTURE, COMPARE, INCR.
//
// Ports
//   clock, reset      rising-edge clock, synchronous active-high reset
//   start, mode       scan request (sampled only in IDLE) and max/min select
//   mem_rd_en         read strobe, high only in READ
//   mem_addr          read address, 0 outside READ
//   mem_rd_data       read data, valid the cycle after mem_rd_en
//   busy              high from the cycle after start through the DONE cycle
//   done              one-cycle pulse, result outputs valid
//   result_value      extreme element of the last completed scan
//   result_index      lowest index holding result_value
//
// Optional feature macro: SIGNED_COMPARE_EN
//   Defined: elements are two's-complement and compared signed.
//   Undefined (default): elements are compared unsigned.
module array_extreme_finder #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result_value,
  output logic [ADDR_WIDTH-1:0] result_index
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_COMPARE = 3'd3,
    S_INCR    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                    mode_q, mode_d;
  logic [DATA_WIDTH-1:0]   elem_q, elem_d;
  logic [DATA_WIDTH-1:0]   best_q, best_d;
  logic [ADDR_WIDTH-1:0]   best_idx_q, best_idx_d;
  logic [DATA_WIDTH-1:0]   res_val_q, res_val_d;
  logic [ADDR_WIDTH-1:0]   res_idx_q, res_idx_d;
  logic                    last_elem;

  // Strict comparison so that ties keep the earlier index.
  function automatic logic is_better(input logic [DATA_WIDTH-1:0] cand,
                                     input logic [DATA_WIDTH-1:0] ref_val,
                                     input logic                  min_mode);
`ifdef SIGNED_COMPARE_EN
    logic signed [DATA_WIDTH-1:0] cand_s;
    logic signed [DATA_WIDTH-1:0] ref_s;
    cand_s = $signed(cand);
    ref_s  = $signed(ref_val);
    return min_mode ? (cand_s < ref_s) : (cand_s > ref_s);
`else
    return min_mode ? (cand < ref_val) : (cand > ref_val);
`endif
  endfunction

  assign last_elem = (idx_q == LAST_IDX);

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      mode_q     <= 1'b0;
      elem_q     <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      res_val_q  <= '0;
      res_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      elem_q     <= elem_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      res_val_q  <= res_val_d;
      res_idx_q  <= res_idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_READ;
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_COMPARE;
      S_COMPARE: state_d = S_INCR;
      S_INCR:    state_d = last_elem ? S_DONE : S_READ;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    idx_d      = idx_q;
    mode_d     = mode_q;
    elem_d     = elem_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    res_val_d  = res_val_q;
    res_idx_d  = res_idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d  = '0;
          mode_d = mode;
        end
      end
      S_CAPTURE: elem_d = mem_rd_data;
      S_COMPARE: begin
        // Element 0 seeds best unconditionally.
        if ((idx_q == '0) || is_better(elem_q, best_q, mode_q)) begin
          best_d     = elem_q;
          best_idx_d = idx_q;
        end
      end
      S_INCR: begin
        // The index stops at the last element instead of wrapping; the
        // result registers load here so they are already valid while done
        // is high and stay untouched for the rest of every scan.
        if (last_elem) begin
          res_val_d = best_q;
          res_idx_d = best_idx_q;
        end else begin
          idx_d = idx_q + ADDR_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    mem_rd_en = (state_q == S_READ);
    mem_addr  = (state_q == S_READ) ? idx_q : '0;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
  end

  assign result_value = res_val_q;
  assign result_index = res_idx_q;

endmodule

// File: tb/tb_array_extreme_finder.sv
module tb_array_extreme_finder;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int SCAN  = 4 * DEPTH + 1;

  logic          clock;
  logic          reset;
  logic          start;
  logic          mode;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic          busy;
  logic          done;
  logic [DW-1:0] result_value;
  logic [AW-1:0] result_index;

  array_extreme_finder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .busy(busy), .done(done), .result_value(result_value),
    .result_index(result_index)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int v;
    int idx;
    int cyc;
  } exp_t;

  logic [DW-1:0] mem [DEPTH];
  exp_t          sb [$];
  int            rd_log [$];
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;
  logic          rst_prev = 1'b1;
  int            last_val = 0;
  int            last_idx = 0;

  // Synchronous-read memory: one cycle latency.
  initial mem_rd_data = '0;
  always @(posedge clock) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rst_prev <= reset;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Element value under the active comparison rule.
  function automatic int key(input logic [DW-1:0] x);
`ifdef SIGNED_COMPARE_EN
    return int'($signed(x));
`else
    return int'(x);
`endif
  endfunction

  // Reference: first index whose key is the extreme over the whole array.
  function automatic void ref_model(input logic m, output int v, output int idx);
    int best;
    best = 0;
    for (int k = 1; k < DEPTH; k++) begin
      if (m ? (key(mem[k]) < key(mem[best])) : (key(mem[k]) > key(mem[best])))
        best = k;
    end
    v   = int'(mem[best]);
    idx = best;
  endfunction

  // Monitor: scoreboard pops on done, result stability, idle address, reset state.
  always @(negedge clock) begin
    exp_t e;
    if (rst_prev) begin
      last_val = 0;
      last_idx = 0;
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_rd_en", 32'(mem_rd_en), 32'd0);
      chk("reset_addr", 32'(mem_addr), 32'd0);
      chk("reset_value", 32'(result_value), 32'd0);
      chk("reset_index", 32'(result_index), 32'd0);
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result_value", 32'(result_value), 32'(e.v));
          chk("result_index", 32'(result_index), 32'(e.idx));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("busy_in_done", 32'(busy), 32'd1);
          last_val = e.v;
          last_idx = e.idx;
        end
      end else begin
        chk("result_hold_value", 32'(result_value), 32'(last_val));
        chk("result_hold_index", 32'(result_index), 32'(last_idx));
      end
      if (mem_rd_en) rd_log.push_back(int'(mem_addr));
      else chk("idle_addr", 32'(mem_addr), 32'd0);
    end
  end

  // Issue a scan at this negedge; c0 is the cycle in which start is sampled.
  task automatic issue(input logic m, output int c0);
    exp_t e;
    int v, idx;
    ref_model(m, v, idx);
    c0 = cyc;
    e.v = v; e.idx = idx; e.cyc = c0 + SCAN;
    sb.push_back(e);
    rd_log.delete();
    start = 1'b1;
    mode  = m;
    @(negedge clock);
    start = 1'b0;
    mode  = 1'($urandom_range(0, 1));  // must not affect the running scan
    #1;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < SCAN + 10) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic check_reads();
    chk("read_count", 32'(rd_log.size()), 32'(DEPTH));
    for (int k = 0; k < rd_log.size() && k < DEPTH; k++)
      chk("read_addr", 32'(rd_log[k]), 32'(k));
  endtask

  task automatic run_scan(input logic m);
    int c0;
    @(negedge clock);
    issue(m, c0);
    wait_done();
    check_reads();
    @(negedge clock);
    #1;
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  initial begin
    int c0;
    reset = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    for (int k = 0; k < DEPTH; k++) mem[k] = DW'(k);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);

    // Ascending memory, both modes
    run_scan(1'b0);
    run_scan(1'b1);

    // Constant memory
    for (int k = 0; k < DEPTH; k++) mem[k] = 8'h7A;
    run_scan(1'b0);
    run_scan(1'b1);

    // Ties keep the lowest index
    for (int k = 0; k < DEPTH; k++) mem[k] = DW'(k % 9);
    mem[3] = 8'h09; mem[11] = 8'h09;
    run_scan(1'b0);
    for (int k = 0; k < DEPTH; k++) mem[k] = 8'h20 + DW'(k);
    mem[5] = 8'h01; mem[7] = 8'h01;
    run_scan(1'b1);

    // Signed versus unsigned interpretation
    for (int k = 0; k < DEPTH; k++) mem[k] = 8'h00;
    mem[2] = 8'hF0; mem[9] = 8'h05;
    run_scan(1'b0);
    run_scan(1'b1);

    // start pulses during the scan and in the DONE cycle are ignored
    for (int k = 0; k < DEPTH; k++) mem[k] = DW'($urandom);
    @(negedge clock);
    issue(1'b0, c0);
    wait_until(c0 + 10);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_until(c0 + SCAN);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    #1;
    chk("busy_after_ignored_start", 32'(busy), 32'd0);
    check_reads();
    repeat (SCAN + 10) @(negedge clock);
    chk("no_extra_done", 32'(sb.size()), 32'd0);

    // Reset mid-scan abandons the scan
    @(negedge clock);
    issue(1'b1, c0);
    wait_until(c0 + 30);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
    repeat (SCAN + 10) @(negedge clock);
    #1;
    chk("no_done_after_reset", 32'(busy), 32'd0);
    run_scan(1'b1);

    // Randomized scans
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < DEPTH; k++) begin
        case ($urandom_range(0, 3))
          0: mem[k] = DW'($urandom_range(0, 3));
          1: mem[k] = DW'($urandom_range(252, 255));
          default: mem[k] = DW'($urandom);
        endcase
      end
      run_scan(1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
